// File: rtl/rr_mux_reg.sv
// N-channel valid/ready multiplexer with run-time round-robin or fixed-priority
// arbitration feeding a single registered, one-deep output stage.
module rr_mux_reg #(
  parameter  int WIDTH  = 16,
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [NUM_CH*WIDTH-1:0]   in_data,
  input  logic [NUM_CH-1:0]         in_valid,
  output logic [NUM_CH-1:0]         in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [CH_W-1:0]           out_ch,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [15:0]               beat_cnt
);

  logic [WIDTH-1:0] data_p1;
  logic [CH_W-1:0]  ch_p1;
  logic             vld_p1;
  logic [15:0]      cnt_p1;
  logic [CH_W-1:0]  ptr;

  logic [CH_W-1:0]  gnt;
  logic [CH_W-1:0]  base;
  logic             load;
  int               idx;
  logic             found;

  function automatic logic [CH_W-1:0] next_ptr(input logic [CH_W-1:0] g);
    return (g == CH_W'(NUM_CH - 1)) ? '0 : CH_W'(g + 1'b1);
  endfunction

  // Arbitration: scan upward from base with wrap-around; base is 0 in fixed priority.
  always_comb begin
    base  = mode ? '0 : ptr;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(base) + k) % NUM_CH;
      if (!found && in_valid[CH_W'(idx)]) begin
        found = 1'b1;
        gnt   = CH_W'(idx);
      end
    end
  end

  assign load     = !rst && (!vld_p1 || out_ready) && (|in_valid);
  assign in_ready = load ? (NUM_CH'(1) << gnt) : '0;

  // Stage p1: registered output beat
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
      cnt_p1  <= '0;
      ptr     <= '0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= in_data[gnt*WIDTH +: WIDTH];
      ch_p1   <= gnt;
      cnt_p1  <= cnt_p1 + 16'd1;
      if (!mode) ptr <= next_ptr(gnt);
    end else if (vld_p1 && out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_data  = data_p1;
  assign out_ch    = ch_p1;
  assign out_valid = vld_p1;
  assign beat_cnt  = cnt_p1;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Randomised and directed bench for rr_mux_reg against a behavioural
// arbitration model; each comparison is an immediate assertion.
module tb_rr_mux_reg;
  localparam int WIDTH  = 16;
  localparam int NUM_CH = 4;
  localparam int CH_W   = $clog2(NUM_CH);

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    mode;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [CH_W-1:0]         out_ch;
  logic                    out_valid;
  logic                    out_ready;
  logic [15:0]             beat_cnt;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic        m_vld  = 1'b0;
  logic [15:0] m_data = '0;
  int          m_ch   = 0;
  logic [15:0] m_cnt  = '0;
  int          m_ptr  = 0;

  rr_mux_reg #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Fixed priority: lowest valid index. Round-robin: lowest valid index at or
  // above the pointer, otherwise lowest valid index overall.
  function automatic int model_grant();
    int g;
    g = -1;
    if (!mode) begin
      for (int i = NUM_CH - 1; i >= m_ptr; i--) if (in_valid[i]) g = i;
    end
    if (g < 0) begin
      for (int i = NUM_CH - 1; i >= 0; i--) if (in_valid[i]) g = i;
    end
    return g;
  endfunction

  task automatic step();
    int          g;
    logic        ld;
    logic [3:0]  exp_rdy;
    logic [15:0] d;
    #1;
    g  = model_grant();
    ld = !rst && (!m_vld || out_ready) && (in_valid != 0);
    exp_rdy = '0;
    d = '0;
    if (ld) begin
      exp_rdy[g] = 1'b1;
      d = in_data[g*WIDTH +: WIDTH];
    end
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (rst) begin
      m_vld = 1'b0; m_data = '0; m_ch = 0; m_cnt = '0; m_ptr = 0;
    end else if (ld) begin
      m_vld = 1'b1; m_data = d; m_ch = g; m_cnt = m_cnt + 16'd1;
      if (!mode) m_ptr = (g + 1) % NUM_CH;
    end else if (m_vld && out_ready) begin
      m_vld = 1'b0;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_vld));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_ch", 32'(out_ch), 32'(m_ch));
    chk("beat_cnt", 32'(beat_cnt), 32'(m_cnt));
  endtask

  task automatic set_data_a();
    for (int i = 0; i < NUM_CH; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'(16'hA000 + i);
  endtask

  initial begin
    // reset held with all channels valid
    rst = 1'b1; mode = 1'b0; out_ready = 1'b1; in_valid = 4'b1111; set_data_a();
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);

    // round-robin sweep from release
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_seq_ch", 32'(out_ch), 32'(i % 4));
      chk("rr_seq_data", 32'(out_data), 32'(16'hA000 + (i % 4)));
    end
    chk("rr_beat_cnt", 32'(beat_cnt), 32'd8);

    // fixed priority
    mode = 1'b1; in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fp_ch1", 32'(out_ch), 32'd1);
    end
    in_valid = 4'b1000;
    step();
    chk("fp_ch3", 32'(out_ch), 32'd3);

    // backpressure
    mode = 1'b0; in_valid = 4'b0100; in_data[2*WIDTH +: WIDTH] = 16'h1234;
    step();
    chk("bp_load", 32'(out_data), 32'h1234);
    out_ready = 1'b0; in_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold", 32'(out_data), 32'h1234);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_ch", 32'(out_ch), 32'd0);
    chk("bp_release_vld", 32'(out_valid), 32'd1);

    // drain with no input: valid drops, data holds
    in_valid = 4'b0000;
    step();
    chk("drain_vld", 32'(out_valid), 32'd0);

    // wrap with sparse valid
    in_valid = 4'b0100;
    step();
    in_valid = 4'b0011;
    step();
    chk("wrap_ch0", 32'(out_ch), 32'd0);
    step();
    chk("wrap_ch1", 32'(out_ch), 32'd1);

    // randomised traffic
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 31) == 0);
      mode      = 1'($urandom_range(0, 1));
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom};
      step();
    end

    // reset mid-stream under backpressure
    rst = 1'b0; mode = 1'b0; out_ready = 1'b1; in_valid = 4'b1111; set_data_a();
    step(); step();
    out_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_vld", 32'(out_valid), 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    step();
    chk("mid_rst_ch0", 32'(out_ch), 32'd0);

    // beat counter wrap
    for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++) step();
    chk("cnt_ffff", 32'(beat_cnt), 32'hFFFF);
    step();
    chk("cnt_wrap", 32'(beat_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rr_mux_reg.md
Name: rr_mux_reg

Overview:
- Parametrised successor to the datapath 2:1 select: an N-channel, WIDTH-bit multiplexer with arbitrated selection and a registered output stage.
- Each channel uses a valid/ready handshake.
- Arbitration mode is round-robin or fixed priority, chosen at run time.
- Sits between multiple producers (ALU result, load data, immediate path, debug port) and one shared consumer such as the register-file write port.

Parameters:
- WIDTH, 16, data width per channel.
- NUM_CH, 4, number of input channels; legal range 2..16.
- CH_W, $clog2(NUM_CH), width of the channel index; derived, never overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = round-robin, 1 = fixed priority (channel 0 highest).
- in_data  input  NUM_CH*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready; combinational.
- out_data  output  WIDTH  registered selected data.
- out_ch  output  CH_W  registered index of the channel that supplied out_data.
- out_valid  output  1  registered valid.
- out_ready  input  1  consumer ready.
- beat_cnt  output  16  count of input beats accepted; wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_ch=0, beat_cnt=0.
  - Round-robin pointer ptr=0.
  - in_ready=0 while rst is high.
- Output register is one entry deep.
  - load = !rst && (!out_valid || out_ready) && (|in_valid).
- Grant search (combinational):
  - mode=0: first asserted in_valid scanning ptr, ptr+1, ..., NUM_CH-1, 0, ..., ptr-1 (wrap-around).
  - mode=1: lowest-index asserted in_valid; ptr is ignored.
- in_ready[g] = load for the granted channel g; all other in_ready bits = 0. Exactly zero or one bit is set.
- On a load edge:
  - out_data <= in_data[g]; out_ch <= g; out_valid <= 1; beat_cnt <= beat_cnt+1.
  - ptr <= (g==NUM_CH-1) ? 0 : g+1, in mode=0 only. ptr holds in mode=1.
- Output handshake and hold:
  - out_valid && out_ready && no in_valid: out_valid <= 0 next edge; out_data and out_ch hold their last values.
  - out_valid && !out_ready: output registers hold, in_ready=0, ptr holds, beat_cnt holds (backpressure).
  - Simultaneous drain and load (out_valid && out_ready && any in_valid): new beat replaces old in the same edge. Sustained throughput is 1 beat/cycle; there is no bubble.
- Latency: input accepted at edge N appears on out_data/out_valid immediately after edge N (1-cycle latency).
- Round-robin fairness: with all channels continuously valid and out_ready=1, grants cycle 0,1,...,NUM_CH-1,0,...
- mode change: takes effect on the next grant decision. ptr retains its value, so returning to mode=0 resumes from the stored pointer.
- Producer rules:
  - A producer must hold in_data/in_valid stable until in_ready.
  - The block does not require this for correctness. An unaccepted channel may drop valid without effect.
- Reset mid-operation: a pending output beat is discarded (out_valid=0 after the edge), ptr and beat_cnt clear, no in_ready pulse that cycle.
- No combinational path from in_valid to out_valid. in_ready depends on in_valid, out_valid, out_ready, mode and ptr.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=4'b1111 -> out_valid=0, in_ready=0, beat_cnt=0. Release: first grant is channel 0, out_ch=0 next cycle.
- Round-robin: NUM_CH=4, mode=0, all valid, data ch i = 16'hA000+i, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3. out_data 16'hA000..16'hA003 repeating. beat_cnt=8.
- Fixed priority: mode=1, in_valid=4'b1010 steady -> out_ch=1 every cycle, channel 3 never granted. Then in_valid=4'b1000 -> out_ch=3.
- Backpressure: one beat from ch 2 (16'h1234) loaded, out_ready=0 for 3 cycles with ch 0 valid -> out_data stays 16'h1234, in_ready=0, beat_cnt unchanged. out_ready=1 -> ch 0 loaded the same edge, no bubble.
- Wrap and sparse valid: ptr=3 (after a grant to ch 2), in_valid=4'b0011 -> grant ch 0, then ptr=1 -> grant ch 1. Separately force beat_cnt to 0xFFFF via 65535 beats -> the next beat gives 0x0000.
- Reset mid-stream: assert rst while out_valid=1 and out_ready=0 -> out_valid=0 after that edge, next grant starts from ch 0.
